// File: rtl/cpu_16bit_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU: opcodes, field positions, storage sizes.
package cpu_16bit_pkg;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 8;
   localparam int IMEM_DEPTH = 256;
   localparam int DMEM_DEPTH = 256;
   localparam int NUM_REGS   = 16;

   // Instruction field bit positions
   localparam int OP_HI    = 15;
   localparam int OP_LO    = 12;
   localparam int RD_HI    = 11;
   localparam int RD_LO    = 8;
   localparam int RS_HI    = 7;
   localparam int RS_LO    = 4;
   localparam int RT_HI    = 3;
   localparam int RT_LO    = 0;
   localparam int IMM8_HI  = 7;
   localparam int IMM8_LO  = 0;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_SLT  = 4'h6,
      OP_SLL  = 4'h7,
      OP_SRL  = 4'h8,
      OP_LI   = 4'h9,
      OP_LUI  = 4'hA,
      OP_LW   = 4'hB,
      OP_SW   = 4'hC,
      OP_BEQ  = 4'hD,
      OP_JMP  = 4'hE,
      OP_HALT = 4'hF
   } opcode_t;

endpackage

// File: rtl/cpu_16bit_alu.sv
// Combinational ALU for the register-register and shift opcodes (1-8).
module cpu_16bit_alu
   import cpu_16bit_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        op,
   output logic [DATA_W-1:0] result
);

   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;

   assign a_s = a;
   assign b_s = b;

   always_comb begin
      result = '0;
      case (op)
         OP_ADD: result = a + b;
         OP_SUB: result = a - b;
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_SLT: result = (a_s < b_s) ? 16'd1 : 16'd0;
         // Shift amount is the 4-bit immediate, zero-extended into b by the caller
         OP_SLL: result = a << b[3:0];
         OP_SRL: result = a >> b[3:0];
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/cpu_16bit.sv
// Single-cycle 16-bit CPU: decode imem[pc] combinationally, commit all state at the next clock edge.
module cpu_16bit
   import cpu_16bit_pkg::*;
(
   input  logic [15:0] instruction_in,
   input  logic [15:0] load_address,
   input  logic        load_instruction,
   input  logic        clk,
   input  logic        pc_reset,
   output logic [7:0]  pc_out,
   output logic        halted
);

   logic [DATA_W-1:0] imem    [IMEM_DEPTH];
   logic [DATA_W-1:0] regfile [NUM_REGS];
   logic [DATA_W-1:0] dmem    [DMEM_DEPTH];
   logic [ADDR_W-1:0] pc;

   logic [DATA_W-1:0] instr;
   opcode_t           op;
   logic [3:0]        rd;
   logic [3:0]        rs;
   logic [3:0]        rt;
   logic [7:0]        imm8;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;
   logic [ADDR_W-1:0] imm4_sext;
   logic [ADDR_W-1:0] mem_addr;

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              mem_we;
   logic [ADDR_W-1:0] pc_next;
   logic              halt_next;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^load_address[15:8];

   // imem has no reset so a program survives pc_reset
   always_ff @(posedge clk) begin
      if (load_instruction) begin
         imem[load_address[7:0]] <= instruction_in;
      end
   end

   assign instr = imem[pc];
   assign op    = opcode_t'(instr[OP_HI:OP_LO]);
   assign rd    = instr[RD_HI:RD_LO];
   assign rs    = instr[RS_HI:RS_LO];
   assign rt    = instr[RT_HI:RT_LO];
   assign imm8  = instr[IMM8_HI:IMM8_LO];

   // R0 reads as zero regardless of the stored word
   assign rd_val = (rd == 4'd0) ? '0 : regfile[rd];
   assign rs_val = (rs == 4'd0) ? '0 : regfile[rs];
   assign rt_val = (rt == 4'd0) ? '0 : regfile[rt];

   assign alu_b     = (op == OP_SLL || op == OP_SRL) ? {12'd0, rt} : rt_val;
   assign imm4_sext = {{4{rt[3]}}, rt};
   assign mem_addr  = rs_val[7:0] + imm4_sext;

   cpu_16bit_alu u_alu (
      .a      (rs_val),
      .b      (alu_b),
      .op     (instr[OP_HI:OP_LO]),
      .result (alu_result)
   );

   always_comb begin
      wr_en     = 1'b0;
      wr_data   = '0;
      mem_we    = 1'b0;
      pc_next   = pc + 8'd1;
      halt_next = halted;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, OP_SRL: begin
            wr_en   = 1'b1;
            wr_data = alu_result;
         end
         OP_LI: begin
            wr_en   = 1'b1;
            wr_data = {{8{imm8[7]}}, imm8};
         end
         OP_LUI: begin
            wr_en   = 1'b1;
            wr_data = {imm8, rd_val[7:0]};
         end
         OP_LW: begin
            wr_en   = 1'b1;
            wr_data = dmem[mem_addr];
         end
         OP_SW:  mem_we = 1'b1;
         OP_BEQ: begin
            if (rd_val == rs_val) pc_next = pc + 8'd1 + imm4_sext;
         end
         OP_JMP: pc_next = instr[7:0];
         OP_HALT: begin
            pc_next   = pc;
            halt_next = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge pc_reset) begin
      if (!pc_reset) begin
         pc     <= '0;
         halted <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regfile[i] <= '0;
         for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
      end else if (!load_instruction && !halted) begin
         pc     <= pc_next;
         halted <= halt_next;
         if (wr_en && rd != 4'd0) regfile[rd] <= wr_data;
         if (mem_we) dmem[mem_addr] <= rd_val;
      end
   end

   assign pc_out = pc;

endmodule

// File: tb/tb_cpu_16bit.sv
// Directed bench for cpu_16bit: expected values are queued per program, then popped and checked.
module tb_cpu_16bit;

   logic [15:0] instruction_in;
   logic [15:0] load_address;
   logic        load_instruction;
   logic        clk;
   logic        pc_reset;
   logic [7:0]  pc_out;
   logic        halted;

   logic [15:0] sb [$];
   logic [15:0] prog [$];
   int total = 0;
   int bad   = 0;

   cpu_16bit dut (
      .instruction_in   (instruction_in),
      .load_address     (load_address),
      .load_instruction (load_instruction),
      .clk              (clk),
      .pc_reset         (pc_reset),
      .pc_out           (pc_out),
      .halted           (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input logic [15:0] v);
      sb.push_back(v);
   endtask

   task automatic check(input string tag, input logic [15:0] obs);
      logic [15:0] exp;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         exp = sb.pop_front();
         assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   // Holds reset, clears imem, loads prog at address 0, then releases reset into run mode.
   task automatic load_and_start();
      pc_reset         = 1'b0;
      load_instruction = 1'b1;
      for (int i = 0; i < 256; i++) begin
         load_address   = 16'(i);
         instruction_in = 16'h0000;
         cycles(1);
      end
      for (int i = 0; i < prog.size(); i++) begin
         load_address   = 16'(i);
         instruction_in = prog[i];
         cycles(1);
      end
      load_instruction = 1'b0;
      pc_reset         = 1'b1;
   endtask

   initial begin
      instruction_in   = '0;
      load_address     = '0;
      load_instruction = 1'b1;
      pc_reset         = 1'b0;
      #2;

      // Load then run, including reset-state checks
      prog = '{16'h9105, 16'h9203, 16'h1312};
      pc_reset = 1'b0;
      #1;
      expect_val(16'h0000); expect_val(16'h0000); expect_val(16'h0000);
      check("rst_pc", {8'd0, pc_out});
      check("rst_halted", {15'd0, halted});
      check("rst_r1", dut.regfile[1]);
      load_and_start();
      cycles(3);
      expect_val(16'h0008); expect_val(16'h0003);
      check("add_r3", dut.regfile[3]);
      check("add_pc", {8'd0, pc_out});

      // Sign extension, shift, compare, subtract, branches
      prog = '{16'h91FF, 16'h8214, 16'h6312, 16'h2401, 16'hD12F, 16'hD002};
      load_and_start();
      cycles(4);
      expect_val(16'hFFFF); expect_val(16'h0FFF); expect_val(16'h0001); expect_val(16'h0001);
      check("li_r1", dut.regfile[1]);
      check("srl_r2", dut.regfile[2]);
      check("slt_r3", dut.regfile[3]);
      check("sub_r4", dut.regfile[4]);
      cycles(1);
      expect_val(16'h0005);
      check("beq_not_taken_pc", {8'd0, pc_out});
      cycles(1);
      expect_val(16'h0008);
      check("beq_fwd_pc", {8'd0, pc_out});

      // Memory store and load
      prog = '{16'h9110, 16'h922A, 16'hC211, 16'hB511};
      load_and_start();
      cycles(4);
      expect_val(16'h002A); expect_val(16'h002A);
      check("sw_dmem11", dut.dmem[8'h11]);
      check("lw_r5", dut.regfile[5]);

      // BEQ self-loop at address 5
      prog = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hD00F};
      load_and_start();
      cycles(5);
      expect_val(16'h0005);
      check("loop_pc_a", {8'd0, pc_out});
      cycles(10);
      expect_val(16'h0005);
      check("loop_pc_b", {8'd0, pc_out});

      // JMP to F8, HALT there and hold
      prog = '{16'hE0F8};
      load_and_start();
      pc_reset         = 1'b0;
      load_instruction = 1'b1;
      load_address     = 16'h00F8;
      instruction_in   = 16'hF000;
      cycles(1);
      load_instruction = 1'b0;
      pc_reset         = 1'b1;
      cycles(1);
      expect_val(16'h00F8); expect_val(16'h0000);
      check("jmp_pc", {8'd0, pc_out});
      check("pre_halt", {15'd0, halted});
      cycles(1);
      expect_val(16'h0001); expect_val(16'h00F8);
      check("halt_flag", {15'd0, halted});
      check("halt_pc", {8'd0, pc_out});
      cycles(10);
      expect_val(16'h0001); expect_val(16'h00F8);
      check("halt_hold_flag", {15'd0, halted});
      check("halt_hold_pc", {8'd0, pc_out});

      // R0 write discarded, LUI, SLL, AND, OR, XOR
      prog = '{16'h9077, 16'h9134, 16'hA1AB, 16'h7214, 16'h3312, 16'h4412, 16'h5512};
      load_and_start();
      cycles(7);
      expect_val(16'h0000); expect_val(16'hAB34); expect_val(16'hB340);
      expect_val(16'hA300); expect_val(16'hBB74); expect_val(16'h1874);
      check("r0_zero", dut.regfile[0]);
      check("lui_r1", dut.regfile[1]);
      check("sll_r2", dut.regfile[2]);
      check("and_r3", dut.regfile[3]);
      check("or_r4", dut.regfile[4]);
      check("xor_r5", dut.regfile[5]);

      // NOP at 255 wraps pc to 0
      prog = '{16'hE0FF};
      load_and_start();
      cycles(1);
      expect_val(16'h00FF);
      check("wrap_pc_ff", {8'd0, pc_out});
      cycles(1);
      expect_val(16'h0000);
      check("wrap_pc_0", {8'd0, pc_out});

      // Asynchronous reset mid-run after HALT
      prog = '{16'h9105, 16'h9203, 16'h1312, 16'hF000};
      load_and_start();
      cycles(5);
      expect_val(16'h0001); expect_val(16'h0003); expect_val(16'h0008);
      check("pre_rst_halted", {15'd0, halted});
      check("pre_rst_pc", {8'd0, pc_out});
      check("pre_rst_r3", dut.regfile[3]);
      pc_reset = 1'b0;
      #1;
      expect_val(16'h0000); expect_val(16'h0000); expect_val(16'h0000);
      check("async_rst_pc", {8'd0, pc_out});
      check("async_rst_halted", {15'd0, halted});
      check("async_rst_r3", dut.regfile[3]);
      pc_reset = 1'b1;

      // Load mode mid-run freezes pc and registers
      prog = '{16'h9105, 16'h1111, 16'h1111, 16'h1111};
      load_and_start();
      cycles(2);
      expect_val(16'h0002); expect_val(16'h000A);
      check("pre_freeze_pc", {8'd0, pc_out});
      check("pre_freeze_r1", dut.regfile[1]);
      load_instruction = 1'b1;
      load_address     = 16'h0080;
      instruction_in   = 16'h0000;
      cycles(5);
      expect_val(16'h0002); expect_val(16'h000A);
      check("freeze_pc", {8'd0, pc_out});
      check("freeze_r1", dut.regfile[1]);
      load_instruction = 1'b0;
      cycles(2);
      expect_val(16'h0004); expect_val(16'h0028);
      check("resume_pc", {8'd0, pc_out});
      check("resume_r1", dut.regfile[1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_16bit.md
CPU_16BIT -- requirements
Module: cpu_16bit

Interface
REQ-001 The block SHALL have exactly one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL have the following ports:
- clk  input  1  rising-edge system clock.
- pc_reset  input  1  asynchronous active-low reset.
- instruction_in  input  16  instruction word to be loaded.
- load_address  input  16  instruction-memory write address; only bits [7:0] are used.
- load_instruction  input  1  load mode: write imem and pause execution.
- pc_out  output  8  current program counter.
- halted  output  1  high after a HALT instruction has executed.
REQ-003 The block SHALL accept port-order instantiation in the order instruction_in, load_address, load_instruction, clk, pc_reset, pc_out, halted.

Function
REQ-004 The block SHALL be a single-cycle CPU with the following storage:
- imem: 256x16 instruction memory.
- regfile: 16x16 register file, R0 through R15.
- dmem: 256x16 data memory.
- pc: 8 bits.
REQ-005 In load mode (load_instruction=1), each rising clk edge SHALL write imem[load_address[7:0]] <= instruction_in; this write SHALL also occur while pc_reset is asserted.
REQ-006 The CPU SHALL execute when load_instruction=0, pc_reset=1 and halted=0; otherwise pc, regfile and dmem SHALL hold their values.
REQ-007 When executing, the CPU SHALL decode imem[pc] combinationally and commit all state updates on the next rising clk edge, so the latency is one instruction per cycle.
REQ-008 Instruction fields SHALL be: op=[15:12], rd=[11:8], rs=[7:4], rt/imm4=[3:0], imm8=[7:0], imm12=[11:0].
REQ-009 The opcodes SHALL be:
- 0 NOP.
- 1 ADD rd=rs+rt.
- 2 SUB rd=rs-rt.
- 3 AND rd=rs&rt.
- 4 OR rd=rs|rt.
- 5 XOR rd=rs^rt.
- 6 SLT rd=(signed rs<signed rt)?1:0.
- 7 SLL rd=rs<<imm4.
- 8 SRL rd=rs>>imm4 (logical).
REQ-010 The opcodes SHALL further be:
- 9 LI rd=sext(imm8).
- A LUI rd={imm8,rd[7:0]}.
- B LW rd=dmem[(rs+sext(imm4))[7:0]].
- C SW dmem[(rs+sext(imm4))[7:0]]=rd.
- D BEQ: if rd==rs then pc=pc+1+sext(imm4).
- E JMP pc=imm12[7:0].
- F HALT.
REQ-011 All arithmetic SHALL be modulo 2^16 with no flags and no exceptions.
REQ-012 PC arithmetic SHALL be modulo 256, so 255+1 wraps to 0 and branch targets wrap.
REQ-013 R0 SHALL always read 0, and writes to R0 SHALL be discarded.
REQ-014 Register reads SHALL be combinational, so an instruction sees the results of all earlier instructions without hazards.
REQ-015 LW SHALL read dmem asynchronously and write rd at the clock edge.
REQ-016 SW SHALL write dmem at the clock edge.
REQ-017 HALT SHALL set halted=1 at its clock edge and leave pc at the HALT address; halted SHALL clear only on reset.
REQ-018 Every non-branch, non-jump, non-HALT instruction SHALL advance pc by 1.
REQ-019 If load_instruction rises mid-program, execution SHALL pause with state intact and resume at the same pc when load_instruction falls.

Reset
REQ-020 When pc_reset=0, the block SHALL asynchronously set pc=0, halted=0, all registers to 0 and all dmem words to 0.
REQ-021 imem SHALL NOT be affected by reset.
REQ-022 imem SHALL power up with all words at 0000 (NOP).
REQ-023 After pc_reset rises with load_instruction=0, the first rising edge SHALL execute imem[0].

Structure
REQ-024 A shared package cpu_16bit_pkg SHALL hold the opcode constants, the instruction field bit positions, IMEM_DEPTH=256, DMEM_DEPTH=256 and NUM_REGS=16.
REQ-025 A sub-module cpu_16bit_alu SHALL implement the combinational ALU for ops 1-8: inputs a, b and op; output 16-bit result.
REQ-026 regfile and dmem SHALL be named arrays so the bench can access them hierarchically.

Verification
REQ-027 Load then run:
- Load imem[0..2] with LI R1,5 = 9105; LI R2,3 = 9203; ADD R3,R1,R2 = 1312.
- Release reset with load_instruction=0.
- After 3 cycles: R3=0008 and pc_out=3.
REQ-028 Sign, shift and compare: LI R1,0xFF (R1=FFFF); SRL R2,R1,4 -> R2=0FFF; SLT R3,R1,R2 -> R3=1; SUB R4,R0,R1 -> R4=0001.
REQ-029 Memory: LI R1,0x10; LI R2,0x2A; SW R2,[R1+1]; LW R5,[R1+1] -> dmem[0x11]=002A and R5=002A.
REQ-030 Control: BEQ R0,R0,-1 at address 5 loops at pc=5 indefinitely; JMP 0x0F8 sets pc=F8; HALT sets halted=1 and pc held over 10 further cycles.
REQ-031 Boundaries:
- A write to R0 leaves R0=0.
- A NOP at imem[255] wraps pc to 0.
- Asserting pc_reset low mid-run zeroes pc, halted and registers immediately without a clock edge.
- Raising load_instruction mid-run freezes pc for its duration.
